// File: rtl/mux_4x1_rr_arbiter_if.sv
// Bundle of the four requester inputs and the shared registered output stage.
// The master view belongs to the arbiter; the slave view belongs to the producers and the consumer.
interface mux_4x1_rr_arbiter_if #(
    parameter int WIDTH     = 4,
    parameter int SEL_WIDTH = 2
);
    logic [3:0]           req;
    logic [WIDTH-1:0]     data_in_0;
    logic [WIDTH-1:0]     data_in_1;
    logic [WIDTH-1:0]     data_in_2;
    logic [WIDTH-1:0]     data_in_3;
    logic [3:0]           ack;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SEL_WIDTH-1:0] sel;

    modport master (
        input  req,
        input  data_in_0,
        input  data_in_1,
        input  data_in_2,
        input  data_in_3,
        input  out_ready,
        output ack,
        output out_data,
        output out_valid,
        output sel
    );

    modport slave (
        output req,
        output data_in_0,
        output data_in_1,
        output data_in_2,
        output data_in_3,
        output out_ready,
        input  ack,
        input  out_data,
        input  out_valid,
        input  sel
    );
endinterface

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter over four requesters that feeds a single registered output stage
// with a valid/ready handshake; a word is never lost while the consumer applies backpressure.
module mux_4x1_rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    mux_4x1_rr_arbiter_if.master    bus
);

    logic [WIDTH-1:0]     r_out_data;
    logic                 r_out_valid;
    logic [SEL_WIDTH-1:0] r_sel;
    logic [1:0]           r_last;
    logic [3:0]           r_ack;

    logic                 w_load;
    logic                 w_found;
    logic [1:0]           w_idx;
    logic [1:0]           w_grant;
    logic [WIDTH-1:0]     w_mux_data;

    // Load whenever someone is asking and the output slot is empty or draining this cycle.
    assign w_load = (|bus.req) & (~r_out_valid | bus.out_ready);

    always_comb begin
        w_found = 1'b0;
        w_grant = r_last;
        w_idx   = r_last;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        w_mux_data = bus.data_in_0;
        case (w_grant)
            2'd0:    w_mux_data = bus.data_in_0;
            2'd1:    w_mux_data = bus.data_in_1;
            2'd2:    w_mux_data = bus.data_in_2;
            default: w_mux_data = bus.data_in_3;
        endcase
    end

    // Pointer resets to 3 so requester 0 wins the first arbitration after reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_sel       <= '0;
            r_last      <= 2'd3;
            r_ack       <= 4'b0000;
        end else begin
            r_ack <= 4'b0000;
            if (w_load) begin
                r_out_data  <= w_mux_data;
                r_out_valid <= 1'b1;
                r_sel       <= SEL_WIDTH'(w_grant);
                r_last      <= w_grant;
                r_ack       <= 4'b0001 << w_grant;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.sel       = r_sel;
    assign bus.ack       = r_ack;

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Directed, table-driven bench for the round-robin arbiter with a few hand-written
// multi-cycle sequences for fairness and reset-during-handshake.
module tb_mux_4x1_rr_arbiter;

    typedef struct {
        string      name;
        logic       rstN;
        logic [3:0] req;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
        logic       ready;
        logic       expValid;
        logic [3:0] expData;
        logic [1:0] expSel;
        logic [3:0] expAck;
    } vec_t;

    logic clk;
    logic rstN;
    int   testsRun;
    int   testsFailed;
    vec_t vecs[$];

    mux_4x1_rr_arbiter_if #(.WIDTH(4), .SEL_WIDTH(2)) bus ();

    mux_4x1_rr_arbiter #(.WIDTH(4), .SEL_WIDTH(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input string name, input logic r, input logic [3:0] req,
                          input logic [3:0] d2, input logic ready,
                          input logic ev, input logic [3:0] ed, input logic [1:0] es,
                          input logic [3:0] ea);
        vec_t v;
        v.name = name; v.rstN = r; v.req = req;
        v.d0 = 4'b0001; v.d1 = 4'b0010; v.d2 = d2; v.d3 = 4'b1000;
        v.ready = ready; v.expValid = ev; v.expData = ed; v.expSel = es; v.expAck = ea;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        rstN          = v.rstN;
        bus.req       = v.req;
        bus.data_in_0 = v.d0;
        bus.data_in_1 = v.d1;
        bus.data_in_2 = v.d2;
        bus.data_in_3 = v.d3;
        bus.out_ready = v.ready;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [3:0] ed,
                               input logic [1:0] es, input logic [3:0] ea);
        testsRun++;
        if (bus.out_valid !== ev) begin
            testsFailed++;
            $display("[TB] FAIL %s out_valid got %b expected %b", name, bus.out_valid, ev);
        end
        testsRun++;
        if (bus.out_data !== ed) begin
            testsFailed++;
            $display("[TB] FAIL %s out_data got %b expected %b", name, bus.out_data, ed);
        end
        testsRun++;
        if (bus.sel !== es) begin
            testsFailed++;
            $display("[TB] FAIL %s sel got %0d expected %0d", name, bus.sel, es);
        end
        testsRun++;
        if (bus.ack !== ea) begin
            testsFailed++;
            $display("[TB] FAIL %s ack got %b expected %b", name, bus.ack, ea);
        end
    endtask

    task automatic stepAndCheck(input vec_t v);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput(v.name, v.expValid, v.expData, v.expSel, v.expAck);
    endtask

    initial begin
        vec_t v;
        logic [1:0] expSel;
        testsRun    = 0;
        testsFailed = 0;

        //     name          rst req      d2       rdy  valid data     sel    ack
        addVec("reset0",     0, 4'b1111, 4'b0100, 1,   0, 4'b0000, 2'd0, 4'b0000);
        addVec("reset1",     0, 4'b1111, 4'b0100, 1,   0, 4'b0000, 2'd0, 4'b0000);
        addVec("rr0",        1, 4'b1111, 4'b0100, 1,   1, 4'b0001, 2'd0, 4'b0001);
        addVec("rr1",        1, 4'b1111, 4'b0100, 1,   1, 4'b0010, 2'd1, 4'b0010);
        addVec("rr2",        1, 4'b1111, 4'b0100, 1,   1, 4'b0100, 2'd2, 4'b0100);
        addVec("rr3",        1, 4'b1111, 4'b0100, 1,   1, 4'b1000, 2'd3, 4'b1000);
        addVec("rrWrap",     1, 4'b1111, 4'b0100, 1,   1, 4'b0001, 2'd0, 4'b0001);
        addVec("single",     1, 4'b0100, 4'b1010, 1,   1, 4'b1010, 2'd2, 4'b0100);
        addVec("singleDrop", 1, 4'b0000, 4'b1010, 1,   0, 4'b1010, 2'd2, 4'b0000);
        addVec("idle",       1, 4'b0000, 4'b1010, 0,   0, 4'b1010, 2'd2, 4'b0000);
        addVec("bpLoad",     1, 4'b1001, 4'b0100, 0,   1, 4'b1000, 2'd3, 4'b1000);
        addVec("bpHold0",    1, 4'b0001, 4'b0100, 0,   1, 4'b1000, 2'd3, 4'b0000);
        addVec("bpHold1",    1, 4'b0001, 4'b0100, 0,   1, 4'b1000, 2'd3, 4'b0000);
        addVec("bpHold2",    1, 4'b0001, 4'b0100, 0,   1, 4'b1000, 2'd3, 4'b0000);
        addVec("bpHold3",    1, 4'b0001, 4'b0100, 0,   1, 4'b1000, 2'd3, 4'b0000);
        addVec("bpRelease",  1, 4'b0001, 4'b0100, 1,   1, 4'b0001, 2'd0, 4'b0001);
        addVec("bpDrain",    1, 4'b0000, 4'b0100, 1,   0, 4'b0001, 2'd0, 4'b0000);
        addVec("skipTo1",    1, 4'b0010, 4'b0100, 1,   1, 4'b0010, 2'd1, 4'b0010);
        addVec("wrapTo0",    1, 4'b0011, 4'b0100, 1,   1, 4'b0001, 2'd0, 4'b0001);
        addVec("stall",      1, 4'b0000, 4'b0100, 0,   1, 4'b0001, 2'd0, 4'b0000);
        addVec("midReset",   0, 4'b1111, 4'b0100, 0,   0, 4'b0000, 2'd0, 4'b0000);
        addVec("postReset",  1, 4'b1111, 4'b0100, 1,   1, 4'b0001, 2'd0, 4'b0001);
        addVec("postDrain",  1, 4'b0000, 4'b0100, 1,   0, 4'b0001, 2'd0, 4'b0000);

        applyStimulus(vecs[0]);
        @(posedge clk);
        #1;
        foreach (vecs[i]) stepAndCheck(vecs[i]);

        // Fairness: pointer was left at 0, so continuous requests rotate 1,2,3,0,...
        expSel = 2'd1;
        for (int k = 0; k < 8; k++) begin
            v = vecs[2];
            v.name = "fair";
            v.expSel = expSel;
            v.expData = 4'b0001 << expSel;
            v.expAck = 4'b0001 << expSel;
            stepAndCheck(v);
            expSel = expSel + 2'd1;
        end

        // Reset coinciding with a completing handshake: reset must win.
        v = vecs[0];
        v.name = "rstVsHandshake";
        stepAndCheck(v);
        v = vecs[22];
        v.name = "idleAfterRst";
        v.expData = 4'b0000;
        stepAndCheck(v);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
